// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Purpose:
//   Sits between the im2col stage and the systolic array. On start it reads
//   the N x K weight matrix and then the M x N im2col matrix through one
//   registered read port (one address per cycle, no bubbles). Weights are
//   held in output registers as a static packed W bus. The im2col rows are
//   then streamed into X with a diagonal skew: lane n is delayed n cycles,
//   so on stream cycle t lane n carries row (t-n) element n, or 0 when that
//   row is out of range.
//
// Ports:
//   clk      in   1                     rising-edge clock
//   rst      in   1                     synchronous active-high reset
//   start    in   1                     run request, honoured in IDLE/DONE only
//   data_rd  in   DATA_WIDTH            read data for the address sampled at
//                                       the previous rising edge
//   addr_rd  out  ADDR_WIDTH            registered read address
//   W        out  DATA_WIDTH*N*K        weight(n,k) at slot (n*K+k)
//   X        out  DATA_WIDTH*N          skewed lanes, lane n at slot n
//   x_valid  out  1                     X carries stream data
//   busy     out  1                     loading or streaming
//   done     out  1                     run finished (level)
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int                    M           = 20,
  parameter int                    N           = 9,
  parameter int                    K           = 5,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h0000_2000,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 32'h0000_1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        data_rd,
  output logic [ADDR_WIDTH-1:0]        addr_rd,
  output logic [DATA_WIDTH*N*K-1:0]    W,
  output logic [DATA_WIDTH*N-1:0]      X,
  output logic                         x_valid,
  output logic                         busy,
  output logic                         done
);

  // Row counters cover both the K weight columns and the M im2col rows.
  localparam int ROWS_MAX = (M > K) ? M : K;
  localparam int RW       = (ROWS_MAX > 1) ? $clog2(ROWS_MAX) : 1;
  localparam int CW       = (N > 1) ? $clog2(N) : 1;
  localparam int TW       = ((M + N - 1) > 1) ? $clog2(M + N - 1) : 1;
  localparam int T_LAST   = M + N - 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_X = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Coordinates of the next word to issue; ph=0 weights, ph=1 im2col.
  logic                  r_nx_more;
  logic                  r_nx_ph;
  logic [RW-1:0]         r_nx_row;
  logic [CW-1:0]         r_nx_col;

  // Word being issued at the coming edge and the coordinates after it.
  logic                  w_issue;
  logic                  w_ph;
  logic [RW-1:0]         w_row;
  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_row_last;
  logic                  w_ph_nx;
  logic                  w_more_nx;
  logic [RW-1:0]         w_row_nx;
  logic [CW-1:0]         w_col_nx;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Two-stage issue-valid pipeline: stage 2 lines up with data_rd.
  logic                  r_p1_v;
  logic                  r_p1_ph;
  logic [RW-1:0]         r_p1_row;
  logic [CW-1:0]         r_p1_col;
  logic                  r_p2_v;
  logic                  r_p2_ph;
  logic [RW-1:0]         r_p2_row;
  logic [CW-1:0]         r_p2_col;
  logic                  w_last_cap;

  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [DATA_WIDTH*N*K-1:0]    r_w;
  logic [DATA_WIDTH*M*N-1:0]    r_buf;

  logic [TW-1:0]                r_t;
  logic [TW-1:0]                w_t_sel;
  logic [DATA_WIDTH*N-1:0]      r_x;
  logic [DATA_WIDTH*N-1:0]      w_x_nx;
  int                           w_src_row;
  logic                         r_x_valid;
  logic                         r_busy;
  logic                         r_done;

  assign addr_rd = r_addr;
  assign W       = r_w;
  assign X       = r_x;
  assign x_valid = r_x_valid;
  assign busy    = r_busy;
  assign done    = r_done;

  // Select the word to issue this cycle and advance its (row, col, phase).
  always_comb begin
    w_issue    = 1'b0;
    w_ph       = r_nx_ph;
    w_row      = r_nx_row;
    w_col      = r_nx_col;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_issue = 1'b1;
          w_ph    = 1'b0;
          w_row   = '0;
          w_col   = '0;
        end else begin
          w_issue = 1'b0;
        end
      end
      S_LOAD_W, S_LOAD_X: w_issue = r_nx_more;
      default:            w_issue = 1'b0;
    endcase

    w_row_last = w_ph ? RW'(M - 1) : RW'(K - 1);
    w_ph_nx    = w_ph;
    w_more_nx  = 1'b1;
    w_row_nx   = w_row;
    w_col_nx   = w_col + CW'(1);
    if (w_col == CW'(N - 1)) begin
      w_col_nx = '0;
      if (w_row == w_row_last) begin
        w_row_nx = '0;
        // Weights roll straight into im2col; im2col end stops issuing.
        if (!w_ph) begin
          w_ph_nx = 1'b1;
        end else begin
          w_more_nx = 1'b0;
        end
      end else begin
        w_row_nx = w_row + RW'(1);
      end
    end else begin
      w_row_nx = w_row;
    end

    w_addr = (w_ph ? IM2COL_BASE : WEIGHT_BASE)
           + ADDR_WIDTH'(N) * ADDR_WIDTH'(w_row)
           + ADDR_WIDTH'(w_col);
  end

  assign w_last_cap = r_p2_v & r_p2_ph
                    & (r_p2_row == RW'(M - 1))
                    & (r_p2_col == CW'(N - 1));

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_LOAD_W;
        else       w_state_nx = S_IDLE;
      end
      S_LOAD_W: begin
        // Phase flips once the last weight address is out; the next
        // issue is the first im2col address.
        if (r_nx_ph) w_state_nx = S_LOAD_X;
        else         w_state_nx = S_LOAD_W;
      end
      S_LOAD_X: begin
        if (w_last_cap) w_state_nx = S_STREAM;
        else            w_state_nx = S_LOAD_X;
      end
      S_STREAM: begin
        if (r_t == TW'(T_LAST)) w_state_nx = S_DONE;
        else                    w_state_nx = S_STREAM;
      end
      S_DONE: begin
        if (start) w_state_nx = S_LOAD_W;
        else       w_state_nx = S_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Stream index for the coming cycle and the skewed lane values for it.
  always_comb begin
    w_t_sel   = (r_state == S_STREAM) ? (r_t + TW'(1)) : '0;
    w_x_nx    = '0;
    w_src_row = 0;
    for (int n = 0; n < N; n++) begin
      w_src_row = int'(w_t_sel) - n;
      if ((w_src_row >= 0) && (w_src_row < M)) begin
        w_x_nx[n*DATA_WIDTH +: DATA_WIDTH] =
          r_buf[(w_src_row * N + n) * DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_x_nx[n*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Address issue, issue counters and the tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_nx_more <= 1'b0;
      r_nx_ph   <= 1'b0;
      r_nx_row  <= '0;
      r_nx_col  <= '0;
      r_p1_v    <= 1'b0;
      r_p1_ph   <= 1'b0;
      r_p1_row  <= '0;
      r_p1_col  <= '0;
      r_p2_v    <= 1'b0;
      r_p2_ph   <= 1'b0;
      r_p2_row  <= '0;
      r_p2_col  <= '0;
    end else begin
      r_p1_v   <= w_issue;
      r_p1_ph  <= w_ph;
      r_p1_row <= w_row;
      r_p1_col <= w_col;
      r_p2_v   <= r_p1_v;
      r_p2_ph  <= r_p1_ph;
      r_p2_row <= r_p1_row;
      r_p2_col <= r_p1_col;
      if (w_issue) begin
        r_addr    <= w_addr;
        r_nx_more <= w_more_nx;
        r_nx_ph   <= w_ph_nx;
        r_nx_row  <= w_row_nx;
        r_nx_col  <= w_col_nx;
      end
    end
  end

  // Weight capture into the W output registers; row field holds k here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w <= '0;
    end else if (r_p2_v && !r_p2_ph) begin
      r_w[(int'(r_p2_col) * K + int'(r_p2_row)) * DATA_WIDTH +: DATA_WIDTH] <= data_rd;
    end
  end

  // im2col capture; buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && r_p2_v && r_p2_ph) begin
      r_buf[(int'(r_p2_row) * N + int'(r_p2_col)) * DATA_WIDTH +: DATA_WIDTH] <= data_rd;
    end
  end

  // Registered outputs follow the state being entered, so X/x_valid drop
  // on the same edge done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_x_valid <= 1'b0;
      r_t       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == S_LOAD_W) || (w_state_nx == S_LOAD_X) ||
                (w_state_nx == S_STREAM);
      r_done <= (w_state_nx == S_DONE);
      if (w_state_nx == S_STREAM) begin
        r_x       <= w_x_nx;
        r_x_valid <= 1'b1;
        r_t       <= w_t_sel;
      end else begin
        r_x       <= '0;
        r_x_valid <= 1'b0;
        r_t       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int M  = 20;
  localparam int N  = 9;
  localparam int K  = 5;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [AW-1:0] IM2COL_BASE = 32'h0000_2000;
  localparam logic [AW-1:0] WEIGHT_BASE = 32'h0000_1000;
  localparam int NW      = N * K;
  localparam int NX      = M * N;
  localparam int NT      = M + N - 1;
  localparam int CYC     = 270;
  // Word i is on addr_rd in cycle i, returns in cycle i+1, captured at the
  // end of it; streaming starts the cycle after the last capture.
  localparam int FIRST_V = NW + NX + 1;

  logic                 clk     = 1'b0;
  logic                 rst     = 1'b1;
  logic                 start   = 1'b0;
  logic [DW-1:0]        data_rd = '0;
  logic [AW-1:0]        addr_rd;
  logic [DW*N*K-1:0]    W;
  logic [DW*N-1:0]      X;
  logic                 x_valid;
  logic                 busy;
  logic                 done;

  systolic_feeder #(
    .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .IM2COL_BASE(IM2COL_BASE), .WEIGHT_BASE(WEIGHT_BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_rd(data_rd),
    .addr_rd(addr_rd), .W(W), .X(X), .x_valid(x_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  logic [DW-1:0] mem [0:16383];
  always @(posedge clk) data_rd <= mem[addr_rd[13:0]];

  int n_total = 0;
  int n_bad   = 0;

  logic [AW-1:0]     tr_addr [CYC];
  logic              tr_xv   [CYC];
  logic [DW*N-1:0]   tr_x    [CYC];
  logic              tr_done [CYC];
  logic              tr_busy [CYC];
  logic              tr_wz   [CYC];
  logic [DW*N*K-1:0] w_final;

  typedef struct { int t; int lane; logic [DW-1:0] exp; } lane_vec_t;
  typedef struct { int n; int k;    logic [DW-1:0] exp; } wslot_vec_t;
  lane_vec_t  lane_tab [10];
  wslot_vec_t w_tab    [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(int c);
    int k;
    int n;
    if (c < NW) begin
      k = c / N;
      n = c % N;
      return WEIGHT_BASE + AW'(N * k + n);
    end else if (c < NW + NX) begin
      return IM2COL_BASE + AW'(c - NW);
    end else begin
      return IM2COL_BASE + AW'(NX - 1);
    end
  endfunction

  function automatic logic [DW-1:0] model_lane(int t, int n);
    int m;
    m = t - n;
    if (m < 0 || m >= M) return '0;
    return mem[int'(IM2COL_BASE) + N * m + n];
  endfunction

  function automatic logic [DW-1:0] model_w(int n, int k);
    return mem[int'(WEIGHT_BASE) + N * k + n];
  endfunction

  // Pulse start, record CYC cycles; optional start pulse / reset at given cycles.
  task automatic do_run(input int mid_c, input int rst_c);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    for (int c = 0; c < CYC; c++) begin
      @(negedge clk);
      tr_addr[c] = addr_rd;
      tr_xv[c]   = x_valid;
      tr_x[c]    = X;
      tr_done[c] = done;
      tr_busy[c] = busy;
      tr_wz[c]   = (W == '0);
      start = (c == mid_c) ? 1'b1 : 1'b0;
      rst   = (c == rst_c) ? 1'b1 : 1'b0;
    end
    w_final = W;
  endtask

  task automatic check_run(input string tag);
    int fv, lv, cnt, errs, lv0, fv0, idx;
    logic [DW-1:0] a;
    errs = 0;
    for (int c = 0; c < CYC; c++) if (tr_addr[c] !== exp_addr(c)) errs++;
    chk({tag, " addr_seq_errs"}, 64'(errs), 64'd0);

    fv = -1; lv = -1; cnt = 0;
    for (int c = 0; c < CYC; c++) begin
      if (tr_xv[c]) begin
        cnt++;
        if (fv < 0) fv = c;
        lv = c;
      end
    end
    chk({tag, " valid_cycles"}, 64'(cnt), 64'(NT));
    chk({tag, " first_valid"}, 64'(fv), 64'(FIRST_V));
    chk({tag, " last_valid"}, 64'(lv), 64'(FIRST_V + NT - 1));

    fv0 = (fv < 0) ? 0 : fv;
    lv0 = (lv < 0) ? 0 : lv;
    errs = 0;
    for (int t = 0; t < NT; t++) begin
      for (int n = 0; n < N; n++) begin
        if (fv0 + t < CYC) begin
          a = tr_x[fv0 + t][n*DW +: DW];
          if (a !== model_lane(t, n)) errs++;
        end else begin
          errs++;
        end
      end
    end
    chk({tag, " stream_data_errs"}, 64'(errs), 64'd0);

    idx = (lv0 + 1 < CYC) ? lv0 + 1 : CYC - 1;
    chk({tag, " done_edge"}, 64'({tr_done[lv0], tr_done[idx]}), 64'(2'b01));
    chk({tag, " busy_at_done"}, 64'(tr_busy[idx]), 64'd0);

    errs = 0;
    for (int c = 0; c < CYC; c++) if (!tr_xv[c] && tr_x[c] !== '0) errs++;
    chk({tag, " x_idle_zero_errs"}, 64'(errs), 64'd0);
    chk({tag, " start_resp"}, 64'({tr_busy[0], tr_done[0]}), 64'(2'b10));

    errs = 0;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < K; k++)
        if (w_final[(n*K+k)*DW +: DW] !== model_w(n, k)) errs++;
    chk({tag, " w_final_errs"}, 64'(errs), 64'd0);
  endtask

  initial begin
    int e_addr, e_x, e_w, e_xv, e_busy, e_done, errs, r;
    logic [DW-1:0] a;

    lane_tab[0] = '{0,  0, 32'h0000_2000};
    lane_tab[1] = '{0,  1, 32'h0000_0000};
    lane_tab[2] = '{0,  8, 32'h0000_0000};
    lane_tab[3] = '{8,  8, 32'h0000_2008};
    lane_tab[4] = '{8,  0, 32'h0000_2048};
    lane_tab[5] = '{5,  3, 32'h0000_2015};
    lane_tab[6] = '{19, 0, 32'h0000_20AB};
    lane_tab[7] = '{20, 0, 32'h0000_0000};
    lane_tab[8] = '{27, 8, 32'h0000_20B3};
    lane_tab[9] = '{27, 7, 32'h0000_0000};
    w_tab[0] = '{2, 3, 32'h0000_101D};
    w_tab[1] = '{0, 0, 32'h0000_1000};
    w_tab[2] = '{8, 4, 32'h0000_102C};
    w_tab[3] = '{8, 0, 32'h0000_1008};
    w_tab[4] = '{0, 4, 32'h0000_1024};

    for (int i = 0; i < 16384; i++) mem[i] = 32'(i);

    // Reset for 5 cycles, then 50 idle cycles.
    e_addr = 0; e_x = 0; e_w = 0; e_xv = 0; e_busy = 0; e_done = 0;
    for (int c = 0; c < 55; c++) begin
      @(negedge clk);
      if (addr_rd !== '0) e_addr++;
      if (X !== '0)       e_x++;
      if (W !== '0)       e_w++;
      if (x_valid !== 1'b0) e_xv++;
      if (busy !== 1'b0)  e_busy++;
      if (done !== 1'b0)  e_done++;
      if (c == 4) rst = 1'b0;
    end
    chk("idle addr_rd_errs", 64'(e_addr), 64'd0);
    chk("idle X_errs",       64'(e_x),    64'd0);
    chk("idle W_errs",       64'(e_w),    64'd0);
    chk("idle x_valid_errs", 64'(e_xv),   64'd0);
    chk("idle busy_errs",    64'(e_busy), 64'd0);
    chk("idle done_errs",    64'(e_done), 64'd0);

    // Full run with mem[a] = a, plus spot values from the tables.
    do_run(-1, -1);
    check_run("full");
    for (int i = 0; i < 10; i++) begin
      r = FIRST_V + lane_tab[i].t;
      a = tr_x[r][lane_tab[i].lane*DW +: DW];
      chk($sformatf("full lane t=%0d n=%0d", lane_tab[i].t, lane_tab[i].lane), 64'(a), 64'(lane_tab[i].exp));
    end
    for (int i = 0; i < 5; i++) begin
      a = w_final[(w_tab[i].n*K + w_tab[i].k)*DW +: DW];
      chk($sformatf("full W n=%0d k=%0d", w_tab[i].n, w_tab[i].k), 64'(a), 64'(w_tab[i].exp));
    end

    // Restart from DONE with a start pulse mid-LOAD_X that must be ignored.
    do_run(100, -1);
    check_run("start_busy");

    // Reset at stream t=10.
    do_run(-1, FIRST_V + 10);
    r = FIRST_V + 11;
    chk("rst_mid valid_before", 64'(tr_xv[FIRST_V + 10]), 64'd1);
    chk("rst_mid X", 64'(tr_x[r] == '0), 64'd1);
    chk("rst_mid flags", 64'({tr_xv[r], tr_busy[r], tr_done[r], tr_wz[r]}), 64'(4'b0001));
    chk("rst_mid addr", 64'(tr_addr[r]), 64'd0);
    errs = 0;
    for (int c = r; c < CYC; c++)
      if (tr_addr[c] !== '0 || tr_busy[c] || tr_xv[c] || tr_done[c] || !tr_wz[c]) errs++;
    chk("rst_mid stays_idle_errs", 64'(errs), 64'd0);
    do_run(-1, -1);
    check_run("rst_rerun");

    // Restart from DONE with new weight(0,0) and random im2col data.
    @(negedge clk);
    chk("restart done_before", 64'(done), 64'd1);
    mem[int'(WEIGHT_BASE)] = 32'h0000_BEEF;
    for (int i = 0; i < NX; i++) mem[int'(IM2COL_BASE) + i] = $urandom;
    do_run(-1, -1);
    check_run("restart");
    chk("restart done_drop", 64'(tr_done[0]), 64'd0);
    chk("restart W00", 64'(w_final[DW-1:0]), 64'h0000_BEEF);

    // start together with rst, first from DONE, then from IDLE.
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      errs = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (busy || done || x_valid || addr_rd !== '0) errs++;
      end
      chk($sformatf("start_rst pass%0d errs", p), 64'(errs), 64'd0);
    end

    // Randomized memory contents against the reference model.
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 16384; i++) mem[i] = $urandom;
      do_run(-1, -1);
      check_run($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
